vec_mem_sequencer: RTL and testbench

Multi-cycle sequencer for vector memory instructions in the Vec_CPU pipeline. On a decoded vector load/store, it stalls the pipeline by driving the enable of the control pipeline registers low. It then walks all vector lanes through a request/ready handshake with data memory, writing loaded elements into the vector register file. When the last lane completes, it releases the pipeline with a one-cycle `done` pulse.

---
 rtl/vec_mem_sequencer.sv | 158 +++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: stalls the pipeline, walks every lane through a mem_ready handshake, then pulses done.
// Optional watchdog abort is compiled in with `define VEC_SEQ_TIMEOUT_EN.
module vec_mem_sequencer #(
    parameter int LANES   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                cl_mem_op,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*DATA_W-1:0]   vec_rdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      stall,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      vec_wr_en,
    output logic [$clog2(LANES)-1:0]  lane_sel,
    output logic [DATA_W-1:0]         vec_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                store_q, store_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                op_valid;
    logic                stall_raw;

`ifdef VEC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    assign op_valid = (cl_mem_op == 2'b01) || (cl_mem_op == 2'b10);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        store_d   = store_q;
        base_d    = base_q;
        stall_raw = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        vec_wr_en = 1'b0;
        lane_sel  = '0;
`ifdef VEC_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Stall from the start cycle itself so decode holds the instruction.
                if (start && op_valid) begin
                    stall_raw = 1'b1;
                    state_d   = ST_ACCESS;
                    lane_d    = '0;
                    store_d   = (cl_mem_op == 2'b10);
                    base_d    = base_addr;
`ifdef VEC_SEQ_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_ACCESS: begin
                stall_raw = 1'b1;
                mem_re    = ~store_q;
                mem_we    = store_q;
                mem_addr  = base_q + ADDR_W'(lane_q);
                mem_wdata = vec_rdata[int'(lane_q)*DATA_W +: DATA_W];
                lane_sel  = lane_q;
                if (mem_ready) begin
                    vec_wr_en = ~store_q;
`ifdef VEC_SEQ_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    if (lane_q == LAST_LANE) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
`ifdef VEC_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline registers update on the falling edge; the sequencer follows suit.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            store_q <= 1'b0;
`ifdef VEC_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            store_q <= store_d;
`ifdef VEC_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Base address is only observed in ACCESS, so it needs no reset.
    always_ff @(negedge clk) begin
        base_q <= base_d;
    end

    assign stall     = stall_raw & reset;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign vec_wdata = mem_rdata;

`ifdef VEC_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: directed and randomized instructions checked against a per-lane transaction model.
module tb_vec_mem_sequencer;
    localparam int LANES   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [1:0]               cl_mem_op;
    logic [ADDR_W-1:0]        base_addr;
    logic [LANES*DATA_W-1:0]  vec_rdata;
    logic                     mem_ready;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     stall;
    logic                     mem_re;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     vec_wr_en;
    logic [1:0]               lane_sel;
    logic [DATA_W-1:0]        vec_wdata;
    logic                     busy;
    logic                     done;
    logic                     err;

    int tests = 0;
    int fails = 0;

    vec_mem_sequencer #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cl_mem_op(cl_mem_op),
        .base_addr(base_addr), .vec_rdata(vec_rdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .vec_wr_en(vec_wr_en),
        .lane_sel(lane_sel), .vec_wdata(vec_wdata), .busy(busy), .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the rising edge; the DUT samples on the falling edge.
    task automatic step(input logic s, input logic [1:0] op, input logic [31:0] ba,
                        input logic [31:0] vd, input logic rdy, input logic [7:0] rd);
        @(posedge clk);
        start     = s;
        cl_mem_op = op;
        base_addr = ba;
        vec_rdata = vd;
        mem_ready = rdy;
        mem_rdata = rd;
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic e_stall, input logic e_re,
                                input logic e_we, input logic [31:0] e_addr,
                                input logic [7:0] e_wdata, input logic e_wren,
                                input logic [1:0] e_lsel, input logic e_busy,
                                input logic e_done, input logic e_err);
        chk({tag, "/stall"},     stall,     e_stall);
        chk({tag, "/mem_re"},    mem_re,    e_re);
        chk({tag, "/mem_we"},    mem_we,    e_we);
        chk({tag, "/mem_addr"},  mem_addr,  e_addr);
        chk({tag, "/mem_wdata"}, mem_wdata, e_wdata);
        chk({tag, "/vec_wr_en"}, vec_wr_en, e_wren);
        chk({tag, "/lane_sel"},  lane_sel,  e_lsel);
        chk({tag, "/busy"},      busy,      e_busy);
        chk({tag, "/done"},      done,      e_done);
        chk({tag, "/err"},       err,       e_err);
        chk({tag, "/vec_wdata"}, vec_wdata, mem_rdata);
    endtask

    task automatic expect_quiet(input string tag);
        expect_cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Model: one instruction is a start cycle, then per lane (waits stalled cycles
    // followed by one accepted cycle), then one done cycle, then idle.
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [31:0] base,
                             input logic [31:0] vd, input int w0, input int w1,
                             input int w2, input int w3, input bit noisy);
        int waits[4];
        bit valid;
        bit is_ld;
        bit is_st;
        logic [31:0] addr;
        logic [7:0] el;
        waits = '{w0, w1, w2, w3};
        valid = (op == 2'b01) || (op == 2'b10);
        is_ld = (op == 2'b01);
        is_st = (op == 2'b10);
        step(1'b1, op, base, vd, 1'($urandom_range(0, 1)), 8'($urandom));
        if (!valid) begin
            expect_quiet({tag, "/nop_start"});
            step(1'b0, 2'b00, 32'h0, vd, 1'b1, 8'($urandom));
            expect_quiet({tag, "/nop_after"});
            return;
        end
        expect_cycle({tag, "/start"}, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int ln = 0; ln < LANES; ln++) begin
            addr = base + 32'(ln);
            el   = vd[ln*8 +: 8];
            for (int w = 0; w <= waits[ln]; w++) begin
                bit rdy;
                rdy = (w == waits[ln]);
                if (noisy)
                    step(1'b1, 2'($urandom_range(1, 2)), $urandom, vd, rdy, 8'hA0 + 8'(ln));
                else
                    step(1'b0, 2'b00, 32'h0, vd, rdy, 8'hA0 + 8'(ln));
                expect_cycle($sformatf("%s/lane%0d_w%0d", tag, ln, w), 1'b1, is_ld, is_st,
                             addr, el, is_ld & rdy, 2'(ln), 1'b1, 1'b0, 1'b0);
            end
        end
        step(noisy, noisy ? 2'b01 : 2'b00, $urandom, vd, 1'($urandom_range(0, 1)), 8'($urandom));
        expect_cycle({tag, "/done"}, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'b00, 32'h0, vd, 1'($urandom_range(0, 1)), 8'($urandom));
        expect_quiet({tag, "/idle"});
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b1;
        cl_mem_op = 2'b01;
        base_addr = 32'h55;
        vec_rdata = 32'hDEADBEEF;
        mem_ready = 1'b1;
        mem_rdata = 8'h5A;
        #3;
        expect_quiet("reset");
        @(negedge clk);
        #2;
        reset = 1'b1;
        start = 1'b0;

        run_instr("load_dir", 2'b01, 32'h100, 32'h0, 0, 0, 0, 0, 1'b0);
        run_instr("store_dir", 2'b10, 32'h200, 32'h44332211, 0, 2, 0, 0, 1'b0);
        run_instr("op00", 2'b00, 32'h300, 32'h0, 0, 0, 0, 0, 1'b0);
        run_instr("op11", 2'b11, 32'h300, 32'h0, 0, 0, 0, 0, 1'b0);
        run_instr("start_in_access", 2'b01, 32'h400, 32'h0, 1, 0, 1, 0, 1'b1);
        run_instr("addr_wrap", 2'b10, 32'hFFFF_FFFE, 32'hCAFEF00D, 0, 1, 0, 0, 1'b0);

        // Reset mid-ACCESS on lane 2: outputs must clear before the next clock edge.
        step(1'b1, 2'b01, 32'h500, 32'h0, 1'b1, 8'h00);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 8'hA0);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 8'hA1);
        step(1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 8'hA2);
        chk("rst_mid/pre_addr", mem_addr, 32'h502);
        chk("rst_mid/pre_lane", lane_sel, 2'd2);
        #1;
        reset = 1'b0;
        #1;
        expect_quiet("rst_mid/async");
        @(negedge clk);
        #2;
        expect_quiet("rst_mid/held");
        reset = 1'b1;
        start = 1'b0;
        run_instr("after_reset", 2'b01, 32'h600, 32'h0, 0, 0, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_instr($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef VEC_SEQ_TIMEOUT_EN
        step(1'b1, 2'b01, 32'h700, 32'h0, 1'b0, 8'h00);
        for (int c = 0; c < TIMEOUT; c++) begin
            step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
            expect_cycle($sformatf("tmo/wait%0d", c), 1'b1, 1'b1, 1'b0, 32'h700, 8'h00,
                         1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
        expect_cycle("tmo/abort", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00);
        expect_quiet("tmo/after");
        run_instr("tmo_recover", 2'b10, 32'h800, 32'h87654321, 1, 0, 0, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
